dvp_tx: RTL
===========

// Module: dvp_tx
// PURPOSE
//  Camera-side DVP byte-stream transmitter: turns a 16-bit RGB565 pixel stream (vld/sop/eop framing)
//  into an 8-bit cmos bus with vsync/href timing. Output connects directly to the camera capture
//  input. Used as a sensor model for loopback and bench tests, and as a DVP output port.
// PARAMETERS
//  COL        1280  pixels per line (2*COL bytes per href-high period)
//  ROW        720   lines per frame
//  VSYNC_CYC  16    cycles vsync is high per frame
//  VBP_CYC    64    cycles from vsync fall to first href rise
//  HBLK_CYC   32    href-low cycles between lines
//  VFP_CYC    64    cycles from last href fall until return to IDLE
// PORTS
//  clk        in   1   pixel-byte clock
//  rst_n      in   1   asynchronous reset, active low
//  en_tx      in   1   transmit enable; sampled only in IDLE
//  din        in   16  pixel, RGB565
//  din_vld    in   1   din valid
//  din_sop    in   1   first pixel of frame
//  din_eop    in   1   last pixel of frame
//  din_rdy    out  1   pixel accepted when din_vld & din_rdy (combinational)
//  cmos_dout  out  8   byte bus, high byte first
//  href       out  1   line valid
//  vsync      out  1   frame sync, high pulse at frame start
//  tx_underrun out 1   1-cycle pulse: pixel slot had no valid input
//  tx_err     out  1   1-cycle pulse: sop/eop position mismatch
//  busy       out  1   high whenever state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, byte phase 0. Reset mid-frame aborts immediately.
//  - FSM: IDLE -> VSYNC (VSYNC_CYC) -> VBP (VBP_CYC) -> LINE (2*COL) -> HBLK (HBLK_CYC) -> LINE ...
//    After the ROW-th LINE -> VFP (VFP_CYC) -> IDLE. HBLK is not inserted after the last line.
//  - IDLE: if en_tx & din_vld & din_sop, go to VSYNC without consuming the pixel. If din_vld & !din_sop,
//    din_rdy=1 and the pixel is discarded (flush to frame boundary). Otherwise din_rdy=0.
//  - vsync, href and cmos_dout are registered. vsync is high exactly VSYNC_CYC cycles; href is high
//    exactly 2*COL consecutive cycles per line; href=0 and cmos_dout=0 outside LINE.
//  - LINE: byte phase toggles every cycle. Phase 0: din_rdy=1. The accepted pixel's din[15:8] appears
//    on cmos_dout next cycle, then din[7:0] the cycle after. Phase 1: din_rdy=0.
//  - Underrun: din_vld=0 in a phase-0 slot -> pixel 16'h0000 sent, tx_underrun pulses, counters advance
//    (line timing never stretches).
//  - Framing check on accepted pixels: sop must be set iff col=0,row=0; eop must be set iff
//    col=COL-1,row=ROW-1; a mismatch pulses tx_err. No resync; the frame completes with nominal timing.
//  - en_tx falling mid-frame: current frame completes; the block then stays in IDLE.
//  - Counters: col 0..COL-1 and row 0..ROW-1 wrap at end of frame; the blanking counter is reused per
//    state. Widths are $clog2 of the max count.
//  - Throughput: 1 pixel per 2 clocks in LINE. First byte appears VSYNC_CYC+VBP_CYC+1 cycles after leaving IDLE.
// TESTING
//  All cases use COL=4, ROW=2, VSYNC_CYC=2, VBP_CYC=3, HBLK_CYC=2, VFP_CYC=3.
//  1 Nominal frame: 8 pixels 16'h1100..16'h1107 always valid, en_tx=1. Required: vsync high 2 cycles;
//    href 8 cycles x2 lines separated by 2 low; bytes 11,00,11,01..11,07; no tx_err or tx_underrun.
//  2 Underrun: din_vld=0 for pixel 2 of line 0. Required: bytes 00,00 in that slot; one tx_underrun
//    pulse; href length unchanged.
//  3 Framing: eop asserted on pixel 5. Required: one tx_err at pixel 5 and one at pixel 7; frame
//    timing nominal.
//  4 Flush: 3 non-sop pixels before sop. Required: all 3 consumed in IDLE with no vsync; the frame
//    starts on sop.
//  5 Reset mid-LINE: assert rst_n=0 at byte 5 of line 1. Required: all outputs 0 in the same cycle;
//    a following full frame is byte-exact.
//  6 Loopback into the capture block (COL=4, ROW=2): captured 16-bit pixels equal the sent pixels,
//    with sop on pixel 0 and eop on the last pixel.

Source files
------------

// File: rtl/dvp_tx.sv
// dvp_tx: camera-side DVP byte-stream transmitter.
// Turns a 16-bit RGB565 pixel stream (vld/sop/eop framing) into an 8-bit cmos bus with
// vsync/href frame timing. It serves as a sensor model for loopback tests and as a DVP output port.
//
// Ports
//   clk         pixel-byte clock
//   rst_n       asynchronous reset, active low
//   en_tx       transmit enable, sampled only in IDLE
//   din         pixel, RGB565
//   din_vld     din valid
//   din_sop     first pixel of frame
//   din_eop     last pixel of frame
//   din_rdy     pixel accepted when din_vld & din_rdy (combinational)
//   cmos_dout   byte bus, high byte first (registered)
//   href        line valid (registered)
//   vsync       frame sync, high at frame start (registered)
//   tx_underrun 1-cycle pulse: pixel slot had no valid input
//   tx_err      1-cycle pulse: sop/eop position mismatch
//   busy        high whenever the FSM is not in IDLE
module dvp_tx #(
  parameter int unsigned COL       = 1280,
  parameter int unsigned ROW       = 720,
  parameter int unsigned VSYNC_CYC = 16,
  parameter int unsigned VBP_CYC   = 64,
  parameter int unsigned HBLK_CYC  = 32,
  parameter int unsigned VFP_CYC   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_tx,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  output logic        din_rdy,
  output logic [7:0]  cmos_dout,
  output logic        href,
  output logic        vsync,
  output logic        tx_underrun,
  output logic        tx_err,
  output logic        busy
);

  localparam int unsigned CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int unsigned RW = (ROW > 1) ? $clog2(ROW) : 1;
  // href lags the LINE state by one cycle (registered byte), so VFP holds one extra cycle
  // to keep VFP_CYC cycles between the last href fall and the return to IDLE.
  localparam int unsigned VFP_LEN = VFP_CYC + 1;
  localparam int unsigned BMAX_A  = (VSYNC_CYC > VBP_CYC) ? VSYNC_CYC : VBP_CYC;
  localparam int unsigned BMAX_B  = (HBLK_CYC > VFP_LEN) ? HBLK_CYC : VFP_LEN;
  localparam int unsigned BMAX    = (BMAX_A > BMAX_B) ? BMAX_A : BMAX_B;
  localparam int unsigned BW      = (BMAX > 1) ? $clog2(BMAX) : 1;

  typedef enum logic [2:0] {StIdle, StVsync, StVbp, StLine, StHblk, StVfp} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            phase_q, phase_d;

  logic [7:0]      dout_q, lo_q;
  logic            href_q, vsync_q, underrun_q, err_q;

  logic            line_slot;
  logic            first_px, last_px, frame_bad;

  assign line_slot = (state_q == StLine) && !phase_q;
  assign first_px  = (col_q == '0) && (row_q == '0);
  assign last_px   = (col_q == CW'(COL - 1)) && (row_q == RW'(ROW - 1));
  assign frame_bad = (din_sop != first_px) || (din_eop != last_px);

  // Next-state, counters and ready
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    phase_d = phase_q;
    din_rdy = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_tx && din_vld && din_sop) begin
          state_d = StVsync;
          cnt_d   = '0;
        end else if (din_vld && !din_sop) begin
          din_rdy = 1'b1;  // flush stray pixels up to the next frame boundary
        end
      end
      StVsync: begin
        if (cnt_q == BW'(VSYNC_CYC - 1)) begin
          state_d = StVbp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      StVbp: begin
        if (cnt_q == BW'(VBP_CYC - 1)) begin
          state_d = StLine;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      StLine: begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          din_rdy = 1'b1;
        end else if (col_q == CW'(COL - 1)) begin
          col_d = '0;
          cnt_d = '0;
          if (row_q == RW'(ROW - 1)) begin
            row_d   = '0;
            state_d = StVfp;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = StHblk;
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      StHblk: begin
        if (cnt_q == BW'(HBLK_CYC - 1)) begin
          state_d = StLine;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      StVfp: begin
        if (cnt_q == BW'(VFP_LEN - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      phase_q <= phase_d;
    end
  end

  // Output registers: every timing output lags the FSM state by one cycle, so the relative
  // spacing of vsync, href and bytes matches the state durations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      lo_q       <= '0;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      underrun_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      vsync_q    <= (state_q == StVsync);
      href_q     <= (state_q == StLine);
      underrun_q <= line_slot && !din_vld;
      err_q      <= line_slot && din_vld && frame_bad;
      if (line_slot) begin
        // An empty slot still sends a black pixel so line timing never stretches
        dout_q <= din_vld ? din[15:8] : 8'h00;
        lo_q   <= din_vld ? din[7:0] : 8'h00;
      end else if (state_q == StLine) begin
        dout_q <= lo_q;
      end else begin
        dout_q <= 8'h00;
      end
    end
  end

  assign cmos_dout   = dout_q;
  assign href        = href_q;
  assign vsync       = vsync_q;
  assign tx_underrun = underrun_q;
  assign tx_err      = err_q;
  assign busy        = (state_q != StIdle);

endmodule
